m3_ramp_sequencer: RTL and testbench
====================================

# m3_ramp_sequencer

Run/ramp controller for the 3-phase drive. Turns the operator controls (start, force stop, reverse, freq/power INC/DEC) into slew-limited setpoints: a sine-period setpoint `periodO` in clkI cycles and a PWM amplitude setpoint `powerO`. Both feed the step/remain period generator and the PWM stage. Every speed change and every direction reversal is ramped geometrically, so the motor never sees a period step.

## Interface
- PERIOD_MAX, 22'd4000000, slowest sine period in clocks (0.25 Hz at 1 MHz). The sim build uses 22'd400.
- PERIOD_MIN, 22'd40, fastest sine period (25 kHz).
- POWER_MAX, 10'd1023, power saturation ceiling.
- POWER_INIT, 10'd102, power loaded on start.
- POWER_STEP, 10'd32, power change per INC/DEC event.
- SHIFT, 4, geometric rate: per-update change = value>>SHIFT.
- TICK_DIV, 1000, clocks between ramp updates (1 ms). The sim build uses 4.
- clkI  in  1  1 MHz clock.
- nRstI  in  1  reset, asynchronous, active-low.
- m3startI  in  1  level: 1 = run requested.
- m3forceStopI  in  1  level: 1 = immediate stop. Highest priority.
- m3invRotateI  in  1  level: requested direction.
- m3freqINCi / m3freqDECi  in  1  each  level buttons, acted on at rising edge.
- m3powerINCi / m3powerDECi  in  1  each  level buttons, acted on at rising edge.
- periodO  out  22  current period setpoint.
- powerO  out  10  current power setpoint.
- runO  out  1  drive enabled.
- dirO  out  1  applied direction.
- stateO  out  3  FSM state, for debug.

## Operation
- **Input edge detection:** all button inputs pass through a sample flop and a previous-sample flop. An edge is defined as `sample & ~prev`.
- **targetP (22 b):**
  - Reset value is PERIOD_MAX.
  - freqINC edge: `targetP -= targetP>>SHIFT`, floored at PERIOD_MIN.
  - freqDEC edge: `targetP += (targetP>>SHIFT) + 1`, using a 23-bit intermediate and capped at PERIOD_MAX.
  - Both edges in the same cycle: no change.
  - targetP is adjustable in every state.
- **Power:**
  - powerINC / powerDEC edges add or subtract POWER_STEP, saturating at 0 and POWER_MAX.
  - Both edges in the same cycle: no change.
  - Edges are ignored while runO=0.
- **Tick counter:**
  - Counts down from TICK_DIV-1. The tick fires when the count is 0, then the counter reloads.
  - The counter is held at TICK_DIV-1 while in IDLE.
- **Slew toward goal G:** on each tick, d = periodO>>SHIFT, or 1 if that is 0. periodO moves by d toward G and is clamped at G, never overshooting.
- **States:** IDLE=0, SLEW=1, RUN=2, STOPPING=3, REVERSING=4.
  - **IDLE:** periodO=PERIOD_MAX, powerO=0, runO=0. When m3startI=1 and m3forceStopI=0: go to SLEW, powerO<=POWER_INIT, runO<=1, dirO<=m3invRotateI.
  - **SLEW:** G=targetP. When periodO==targetP, go to RUN.
  - **RUN:** when periodO!=targetP, go to SLEW.
  - **STOPPING:** G=PERIOD_MAX. When periodO==PERIOD_MAX, go to IDLE (powerO<=0, runO<=0).
  - **REVERSING:** G=PERIOD_MAX. When periodO==PERIOD_MAX, dirO<=~dirO and go to SLEW.
- **Transition priority, per cycle:**
  1. m3forceStopI=1: go to IDLE from any state. periodO<=PERIOD_MAX, powerO<=0, runO<=0 at the next edge. targetP is kept.
  2. m3startI=0 in SLEW, RUN or REVERSING: go to STOPPING.
  3. m3invRotateI!=dirO in SLEW or RUN: go to REVERSING.
- **Reverse request withdrawn mid-REVERSING:** the ramp still completes to PERIOD_MAX and flips dirO. The block then reverses again from SLEW.
- **start re-asserted in STOPPING:** the ramp completes to IDLE, then restarts from IDLE next cycle.

## Timing
- **Reset values:** periodO=PERIOD_MAX, powerO=0, runO=0, dirO=0, stateO=0, targetP=PERIOD_MAX, tick count=TICK_DIV-1, edge flops=0.
- **Button latency:** input rises before edge N, is sampled at N, and targetP or powerO updates at edge N+1.
- **Level latency:** m3startI, m3forceStopI and m3invRotateI are used unregistered. The state change happens at the first clock edge at which the level is seen.
- **Slew rate:** at most one periodO change per tick, i.e. per TICK_DIV clocks.
- **Reaching the goal:** the compare (periodO==G) moves the FSM to the next state at the edge after the final periodO update.
- **Asynchronous reset mid-ramp:** all registers return to their reset values immediately.

## Test plan
All scenarios use the sim parameters (PERIOD_MAX=400, TICK_DIV=4, SHIFT=4).

1. **Reset:** release reset -> periodO=400, powerO=0, runO=0, stateO=0.
2. **Start and one freqINC:**
   - Start: stateO goes IDLE->SLEW->RUN, powerO=102, dirO=m3invRotateI.
   - One freqINC press: targetP=375. On the next tick periodO=375, then RUN.
3. **Repeated freqINC, then freqDEC:**
   - 40 freqINC presses: periodO ramps down and clamps at 40, never below.
   - freqDEC at 40: targetP=43.
4. **Power saturation:**
   - 30 powerINC presses: powerO saturates at 1023.
   - 40 powerDEC presses: powerO reaches 0.
   - INC and DEC rising in the same cycle: powerO unchanged.
5. **Stop and reverse:**
   - Drop m3startI at periodO=40: periodO ramps to 400, then IDLE with runO=0 and powerO=0.
   - Toggle m3invRotateI while in RUN: ramp to 400, dirO flips, then ramp back to targetP.
6. **Force stop mid-ramp:** m3forceStopI=1 during SLEW -> next edge stateO=0, periodO=400, powerO=0. While forceStop stays high with m3startI=1, the block remains in IDLE.

Source files
------------

// File: rtl/m3_ramp_sequencer.sv
// Run/ramp controller for the 3-phase drive: turns operator controls into
// geometrically slewed period and power setpoints.
module m3_ramp_sequencer #(
  parameter logic [21:0] PERIOD_MAX = 22'd4000000,
  parameter logic [21:0] PERIOD_MIN = 22'd40,
  parameter logic [9:0]  POWER_MAX  = 10'd1023,
  parameter logic [9:0]  POWER_INIT = 10'd102,
  parameter logic [9:0]  POWER_STEP = 10'd32,
  parameter int unsigned SHIFT      = 4,
  parameter int unsigned TICK_DIV   = 1000
) (
  input  logic        clkI,
  input  logic        nRstI,
  input  logic        m3startI,
  input  logic        m3forceStopI,
  input  logic        m3invRotateI,
  input  logic        m3freqINCi,
  input  logic        m3freqDECi,
  input  logic        m3powerINCi,
  input  logic        m3powerDECi,
  output logic [21:0] periodO,
  output logic [9:0]  powerO,
  output logic        runO,
  output logic        dirO,
  output logic [2:0]  stateO
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SLEW      = 3'd1,
    S_RUN       = 3'd2,
    S_STOPPING  = 3'd3,
    S_REVERSING = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [21:0]   period_q, period_d;
  logic [21:0]   target_q, target_d;
  logic [9:0]    power_q, power_d;
  logic          run_q, run_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    btn_smp_q, btn_smp_d;
  logic [3:0]    btn_prv_q, btn_prv_d;

  logic [3:0]    btn_edge;
  logic          tick;
  logic [21:0]   tgt_shr, tgt_inc;
  logic [22:0]   tgt_dec;
  logic [10:0]   pwr_sum;
  logic [9:0]    pwr_adj;
  logic [21:0]   goal, step, slewed;
  logic          slew_en;

  // Button bit order: [3] freqINC, [2] freqDEC, [1] powerINC, [0] powerDEC.
  always_comb begin
    btn_smp_d = {m3freqINCi, m3freqDECi, m3powerINCi, m3powerDECi};
    btn_prv_d = btn_smp_q;
    btn_edge  = btn_smp_q & ~btn_prv_q;

    tgt_shr = target_q >> SHIFT;
    tgt_inc = target_q - tgt_shr;
    if (tgt_inc < PERIOD_MIN) tgt_inc = PERIOD_MIN;
    tgt_dec = {1'b0, target_q} + {1'b0, tgt_shr} + 23'd1;
    target_d = target_q;
    if (btn_edge[3] && !btn_edge[2]) begin
      target_d = tgt_inc;
    end else if (btn_edge[2] && !btn_edge[3]) begin
      target_d = (tgt_dec > {1'b0, PERIOD_MAX}) ? PERIOD_MAX : tgt_dec[21:0];
    end

    pwr_sum = {1'b0, power_q} + {1'b0, POWER_STEP};
    pwr_adj = power_q;
    if (run_q && btn_edge[1] && !btn_edge[0]) begin
      pwr_adj = (pwr_sum > {1'b0, POWER_MAX}) ? POWER_MAX : pwr_sum[9:0];
    end else if (run_q && btn_edge[0] && !btn_edge[1]) begin
      pwr_adj = (power_q < POWER_STEP) ? '0 : power_q - POWER_STEP;
    end

    tick   = (tick_q == '0);
    tick_d = (state_q == S_IDLE || tick) ? TICK_LOAD : tick_q - TW'(1);
  end

  // One geometric step toward the state's goal, clamped so it never overshoots.
  always_comb begin
    goal = (state_q == S_STOPPING || state_q == S_REVERSING) ? PERIOD_MAX : target_q;
    step = period_q >> SHIFT;
    if (step == '0) step = 22'd1;
    slewed = period_q;
    if (period_q < goal) begin
      slewed = (goal - period_q <= step) ? goal : period_q + step;
    end else if (period_q > goal) begin
      slewed = (period_q - goal <= step) ? goal : period_q - step;
    end
    slew_en = tick && (state_q == S_SLEW || state_q == S_STOPPING ||
                       state_q == S_REVERSING);
  end

  always_comb begin
    state_d  = state_q;
    period_d = slew_en ? slewed : period_q;
    power_d  = pwr_adj;
    run_d    = run_q;
    dir_d    = dir_q;
    if (m3forceStopI) begin
      state_d  = S_IDLE;
      period_d = PERIOD_MAX;
      power_d  = '0;
      run_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          period_d = PERIOD_MAX;
          power_d  = '0;
          run_d    = 1'b0;
          if (m3startI) begin
            state_d = S_SLEW;
            power_d = POWER_INIT;
            run_d   = 1'b1;
            dir_d   = m3invRotateI;
          end
        end
        S_SLEW: begin
          if (!m3startI)                  state_d = S_STOPPING;
          else if (m3invRotateI != dir_q) state_d = S_REVERSING;
          else if (period_q == target_q)  state_d = S_RUN;
        end
        S_RUN: begin
          if (!m3startI)                  state_d = S_STOPPING;
          else if (m3invRotateI != dir_q) state_d = S_REVERSING;
          else if (period_q != target_q)  state_d = S_SLEW;
        end
        S_STOPPING: begin
          if (period_q == PERIOD_MAX) begin
            state_d = S_IDLE;
            power_d = '0;
            run_d   = 1'b0;
          end
        end
        S_REVERSING: begin
          // A withdrawn reverse request is not honoured here; the flip still
          // happens and SLEW then sees the mismatch and reverses back.
          if (!m3startI) begin
            state_d = S_STOPPING;
          end else if (period_q == PERIOD_MAX) begin
            state_d = S_SLEW;
            dir_d   = ~dir_q;
          end
        end
        default: begin
          state_d  = S_IDLE;
          period_d = PERIOD_MAX;
          power_d  = '0;
          run_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state_q   <= S_IDLE;
      period_q  <= PERIOD_MAX;
      target_q  <= PERIOD_MAX;
      power_q   <= '0;
      run_q     <= 1'b0;
      dir_q     <= 1'b0;
      tick_q    <= TICK_LOAD;
      btn_smp_q <= '0;
      btn_prv_q <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      target_q  <= target_d;
      power_q   <= power_d;
      run_q     <= run_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      btn_smp_q <= btn_smp_d;
      btn_prv_q <= btn_prv_d;
    end
  end

  assign periodO = period_q;
  assign powerO  = power_q;
  assign runO    = run_q;
  assign dirO    = dir_q;
  assign stateO  = state_q;

endmodule

// File: tb/tb_m3_ramp_sequencer.sv
// Directed self-checking bench for m3_ramp_sequencer using the sim build
// (PERIOD_MAX=400, TICK_DIV=4, SHIFT=4).
module tb_m3_ramp_sequencer;

  logic        clk;
  logic        nRst;
  logic        start, force_stop, inv_rot;
  logic [3:0]  btn;
  logic [21:0] periodO;
  logic [9:0]  powerO;
  logic        runO, dirO;
  logic [2:0]  stateO;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic        range_err = 1'b0;
  logic [21:0] peak;
  logic        got_slew;

  m3_ramp_sequencer #(
    .PERIOD_MAX (22'd400),
    .TICK_DIV   (4)
  ) dut (
    .clkI         (clk),
    .nRstI        (nRst),
    .m3startI     (start),
    .m3forceStopI (force_stop),
    .m3invRotateI (inv_rot),
    .m3freqINCi   (btn[3]),
    .m3freqDECi   (btn[2]),
    .m3powerINCi  (btn[1]),
    .m3powerDECi  (btn[0]),
    .periodO      (periodO),
    .powerO       (powerO),
    .runO         (runO),
    .dirO         (dirO),
    .stateO       (stateO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // periodO must stay within [PERIOD_MIN, PERIOD_MAX] at all times.
  always @(posedge clk)
    if (nRst && (periodO < 22'd40 || periodO > 22'd400)) range_err <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the button mask for two edges, then release long enough to re-arm.
  task automatic press(input logic [3:0] m);
    btn = m;
    cyc(2);
    btn = '0;
    cyc(2);
  endtask

  initial begin
    nRst = 1'b0; start = 1'b0; force_stop = 1'b0; inv_rot = 1'b0; btn = '0;
    cyc(3);
    nRst = 1'b1;
    cyc(1);
    chk("rst_period", periodO, 400);
    chk("rst_power",  powerO,  0);
    chk("rst_run",    runO,    0);
    chk("rst_dir",    dirO,    0);
    chk("rst_state",  stateO,  0);

    inv_rot = 1'b1; start = 1'b1;
    cyc(1);
    chk("start_state", stateO, 1);
    chk("start_power", powerO, 102);
    chk("start_run",   runO,   1);
    chk("start_dir",   dirO,   1);
    cyc(1);
    chk("start_run_state", stateO, 2);

    press(4'b1000);
    cyc(30);
    chk("inc1_state",  stateO,  2);
    chk("inc1_period", periodO, 375);

    for (int i = 0; i < 40; i++) press(4'b1000);
    cyc(400);
    chk("inc40_state",  stateO,  2);
    chk("inc40_period", periodO, 40);

    for (int i = 0; i < 30; i++) press(4'b0010);
    chk("pwr_sat_hi", powerO, 1023);
    for (int i = 0; i < 40; i++) press(4'b0001);
    chk("pwr_sat_lo", powerO, 0);
    press(4'b0010);
    chk("pwr_inc1", powerO, 32);
    press(4'b0011);
    chk("pwr_both", powerO, 32);

    start = 1'b0;
    cyc(1);
    chk("stop_state", stateO, 3);
    cyc(400);
    chk("stop_idle",   stateO,  0);
    chk("stop_period", periodO, 400);
    chk("stop_run",    runO,    0);
    chk("stop_power",  powerO,  0);
    press(4'b0010);
    chk("idle_pwr_ignored", powerO, 0);

    start = 1'b1;
    cyc(1);
    chk("restart_state", stateO, 1);
    cyc(400);
    chk("restart_run",    stateO,  2);
    chk("restart_period", periodO, 40);
    chk("restart_dir",    dirO,    1);

    press(4'b0100);
    cyc(40);
    chk("dec_period", periodO, 43);
    chk("dec_state",  stateO,  2);

    inv_rot = 1'b0;
    cyc(1);
    chk("rev_state", stateO, 4);
    chk("rev_dir_hold", dirO, 1);
    peak = '0;
    for (int i = 0; i < 600; i++) begin
      cyc(1);
      if (periodO > peak) peak = periodO;
    end
    chk("rev_peak",   peak,    400);
    chk("rev_state2", stateO,  2);
    chk("rev_period", periodO, 43);
    chk("rev_dir",    dirO,    0);

    press(4'b0100);
    got_slew = 1'b0;
    for (int i = 0; i < 20 && !got_slew; i++) begin
      if (stateO == 3'd1) got_slew = 1'b1;
      else cyc(1);
    end
    chk("fs_in_slew", got_slew, 1);
    force_stop = 1'b1;
    cyc(1);
    chk("fs_state",  stateO,  0);
    chk("fs_period", periodO, 400);
    chk("fs_power",  powerO,  0);
    chk("fs_run",    runO,    0);
    cyc(10);
    chk("fs_hold", stateO, 0);
    force_stop = 1'b0;
    cyc(1);
    chk("fs_release", stateO, 1);

    cyc(5);
    #3 nRst = 1'b0;
    #1;
    chk("arst_state",  stateO,  0);
    chk("arst_period", periodO, 400);
    chk("arst_power",  powerO,  0);
    chk("arst_run",    runO,    0);
    #2 nRst = 1'b1;
    cyc(2);
    chk("arst_target_state",  stateO,  2);
    chk("arst_target_period", periodO, 400);

    chk("period_range", range_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
